// File: rtl/kernel_key_debounce.sv
// Per-key debouncer for active-low push buttons.
// Each raw pin is synchronised through two flops, then a small FSM demands
// DEBOUNCE_CYCLES consecutive cycles of a new level before the debounced
// output follows it. One-cycle press/release strobes accompany every
// debounced edge. All outputs come straight from flops.
module kernel_key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Count value on which a pending level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  // Two-flop synchroniser; resets to the idle (released) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_q;
    logic             level_nxt;
    logic             press_q;
    logic             press_nxt;
    logic             release_q;
    logic             release_nxt;

    // State, counter and registered outputs for this key.
    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // Next-state logic: any reversion of the pending level restarts from scratch.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        RELEASED: begin
          if (!sync2[g]) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2[g]) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (sync2[g]) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2[g]) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = RELEASED;
            cnt_nxt     = '0;
            level_nxt   = 1'b1;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign key_out[g]       = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
  end

endmodule

// File: doc/kernel_key_debounce.md
KERNEL_KEY_DEBOUNCE -- requirements
Module: kernel_key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before output change (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 SHALL have parameter CNT_W, default 24, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port key_in  input  NUM_KEYS  raw asynchronous key pins, active-low (0 = pressed).
REQ-007 SHALL have port key_out  output  NUM_KEYS  debounced key level, same polarity as key_in; drives the PIO in_port.
REQ-008 SHALL have port press_pulse  output  NUM_KEYS  one-cycle strobe per key on debounced 1->0 transition.
REQ-009 SHALL have port release_pulse  output  NUM_KEYS  one-cycle strobe per key on debounced 0->1 transition.

Function
REQ-010 SHALL pass each key_in bit through a two-flop synchronizer (sync1, sync2) before any other use; all logic is per key and fully independent.
REQ-011 SHALL implement per-key FSM with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT, and a per-key counter cnt of CNT_W bits.
REQ-012 SHALL, in RELEASED with sync2=0, move to PRESS_WAIT with cnt<=1; with sync2=1, remain with cnt<=0.
REQ-013 SHALL, in PRESS_WAIT with sync2=1, return to RELEASED with cnt<=0 (glitch rejected, no output change, no pulse).
REQ-014 SHALL, in PRESS_WAIT with sync2=0 and cnt<DEBOUNCE_CYCLES-1, stay with cnt<=cnt+1.
REQ-015 SHALL, in PRESS_WAIT with sync2=0 and cnt=DEBOUNCE_CYCLES-1, move to HELD, cnt<=0, key_out bit<=0, press_pulse bit<=1 for that single cycle.
REQ-016 SHALL mirror REQ-012..015 for HELD/RELEASE_WAIT with sync2=1 as the pending level, setting key_out bit<=1 and release_pulse bit<=1 on completion.
REQ-017 SHALL drive key_out, press_pulse, release_pulse directly from registers (no combinational path from key_in).
REQ-018 SHALL have latency from a clean raw transition (sampled at edge N) to key_out change of exactly DEBOUNCE_CYCLES+2 clock edges (2 sync + DEBOUNCE_CYCLES count).
REQ-019 SHALL assert press_pulse/release_pulse in the same cycle key_out changes, for exactly one cycle, never both for one key in the same cycle.
REQ-020 SHALL restart the count from zero on any bounce: a pending level that reverts even one cycle before completion yields no output change.
REQ-021 SHALL never let cnt exceed DEBOUNCE_CYCLES-1 nor wrap.
REQ-022 SHALL process simultaneous transitions on several keys independently; multiple pulse bits may be high in the same cycle.

Reset
REQ-023 SHALL, when reset=1 at a clk edge, set sync1, sync2, key_out to all ones, press_pulse and release_pulse to zero, all cnt to 0, all FSMs to RELEASED.
REQ-024 SHALL, on reset asserted mid-count or in HELD, abandon the pending transition without emitting any pulse; a key held low through reset deassertion is debounced afresh and produces press_pulse after DEBOUNCE_CYCLES+2 edges.
REQ-025 SHALL keep outputs at reset values for every cycle reset is high, regardless of key_in.

Verification (DEBOUNCE_CYCLES=8 for simulation)
REQ-026 SHALL verify reset: reset high 3 cycles with key_in=4'b0000 -> key_out=4'b1111, pulses 0 throughout reset.
REQ-027 SHALL verify clean press: key_in[0] 1->0 held 20 cycles -> key_out[0] falls exactly 10 edges after first sampling edge, press_pulse[0] high exactly 1 cycle, no other bits change.
REQ-028 SHALL verify bounce rejection: key_in[1] low 7 cycles, high 1, low 7, high -> key_out[1] stays 1, no pulses; then low 12 cycles -> single press_pulse[1].
REQ-029 SHALL verify release: key_in[2] held pressed until key_out[2]=0, then 0->1 held -> key_out[2] rises after 10 edges with one release_pulse[2], no press_pulse[2].
REQ-030 SHALL verify simultaneous keys and reset mid-count: key_in 4'b1111->4'b0000 together -> all four press_pulse bits high in same cycle; repeat with reset pulsed at count 5 -> no pulse, then press_pulse 10 edges after reset release.
